pos_cell_ctrl: RTL and testbench
================================

# pos_cell_ctrl

Sequencing and arbitration controller for one single-port particle-position cell RAM (depth PARTICLE_NUM, word {posz, posy, posx}, address 0 = particle count, 2-cycle read latency). It sits between the position cache and the RAM. On request it streams every particle of the cell to the force-evaluation pipeline, and it shares the RAM port with the motion-update writer.

## Interface
- DATA_WIDTH, 96: RAM word width.
- ADDR_WIDTH, 8: RAM address width.
- PARTICLE_NUM, 220: RAM depth; the maximum legal particle count is PARTICLE_NUM-1.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_start  in  1  pulse that requests a full-cell stream.
- rd_ready  in  1  consumer can accept; sampled only for issuing new reads.
- rd_busy  out  1  stream in progress.
- rd_valid  out  1  rd_data/rd_pid valid.
- rd_data  out  DATA_WIDTH  particle position.
- rd_pid  out  ADDR_WIDTH  RAM address (1..N) of rd_data.
- rd_done  out  1  one-cycle pulse after the last particle.
- particle_num  out  ADDR_WIDTH  count latched from address 0 (clamped).
- count_err  out  1  sticky flag: the stored count exceeded PARTICLE_NUM-1.
- wr_req  in  1  motion-update write request; held until granted.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_grant  out  1  combinational grant; the write is accepted on a cycle where wr_req & wr_grant.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_rden  out  1  to RAM rden.
- ram_wren  out  1  to RAM wren.
- ram_q  in  DATA_WIDTH  from RAM q.

## Operation
- **States**
  - IDLE.
  - NUM_WAIT: count read issued; waiting 2 cycles.
  - STREAM: issuing addresses 1..N.
  - DRAIN: waiting for in-flight reads.
  - DONE: rd_done pulse, then back to IDLE.
- **IDLE**
  - rd_start moves to NUM_WAIT and registers ram_address=0, ram_rden=1.
  - rd_start while not IDLE is ignored.
- **Arbitration**
  - wr_grant = (state==IDLE) & !rd_start, so reads have priority.
  - A granted write registers ram_address=wr_addr, ram_data=wr_data, ram_wren=1 for exactly one cycle.
  - Back-to-back writes are allowed at one per cycle.
  - Writes to address 0 are legal; the controller does not interpret them.
- **NUM_WAIT**
  - When ram_q carries the count, N = min(ram_q[ADDR_WIDTH-1:0], PARTICLE_NUM-1).
  - If clamping occurred, set count_err.
  - Latch particle_num=N.
  - If N==0, go to DONE; otherwise go to STREAM.
- **STREAM**
  - Each cycle with rd_ready=1, issue address a (starting at 1) with ram_rden=1, then increment a.
  - With rd_ready=0, ram_rden=0 and the address is held.
  - After issuing address N, go to DRAIN.
- **Read pipeline**
  - A 2-deep valid/pid delay line tracks reads.
  - rd_valid/rd_pid come out 2 cycles after issue; rd_data=ram_q.
  - Reads already in flight are always delivered regardless of rd_ready, so the consumer must absorb 2 words after deasserting rd_ready.
- **DRAIN → DONE**: when the delay line is empty; DONE lasts 1 cycle with rd_done=1.
- **Bounds**
  - rd_busy = (state != IDLE).
  - The address counter never exceeds N; no wrap-around is possible.
- **Reset** (asynchronous, at any point)
  - State goes to IDLE; the delay line is cleared and in-flight data is dropped.
  - All outputs go to 0: ram_*, rd_*, particle_num, count_err.
  - wr_grant becomes 1 once the reset is released.

## Timing
- rd_start high in cycle 0 → ram_address=0, ram_rden=1 in cycle 1 → count on ram_q in cycle 3 → particle_num valid and address 1 issued in cycle 4.
- With no stalls:
  - rd_valid in cycles 6..5+N.
  - rd_done in cycle 6+N.
  - rd_busy high from cycle 1 through 6+N.
- Stall: each cycle of rd_ready=0 in STREAM delays all later issue and output by one cycle.
- Write: wr_req & wr_grant in cycle k → ram_wren=1 in cycle k+1.
- Read-after-write on the same address returns new data when the read issues in a cycle after the write.

## Structure
- Put the state encodings and the read-latency constant RD_LAT=2 in the shared define header.
- Use one sub-module, pos_rd_lat_pipe: a 2-stage valid+pid shift register with clear, sized by RD_LAT.

## Test plan
- **Basic stream**: RAM[0]=3, RAM[1..3]=A,B,C; pulse rd_start in cycle 0.
  - rd_valid in cycles 6,7,8 with pid 1,2,3 and data A,B,C.
  - rd_done in cycle 9; particle_num=3.
- **Empty cell**: RAM[0]=0 → no rd_valid; rd_done in cycle 5; rd_busy low from cycle 6.
- **Overflow**: RAM[0]=250 with PARTICLE_NUM=220 → particle_num=219, count_err=1 (sticky), exactly 219 valids.
- **Backpressure**: N=4; rd_ready=0 for 3 cycles starting cycle 5.
  - pids still arrive in order 1..4.
  - Each word is delivered once.
  - rd_done is delayed by 3 cycles.
- **Arbitration**
  - wr_req and rd_start asserted together in IDLE → wr_grant=0; the stream runs.
  - The write is granted in cycle 7+N.
  - Back-to-back writes give ram_wren on consecutive cycles.
- **Reset mid-stream**: assert rst_n=0 during STREAM of N=5 → all outputs are 0 immediately; after release, a new rd_start produces a clean stream.

Source files
------------

// File: rtl/pos_cell_ctrl_pkg.sv
// Shared definitions for the particle-position cell RAM controller:
// read latency of the RAM and the controller state encoding.
package pos_cell_ctrl_pkg;

    // Cycles from ram_rden/ram_address registered to data on ram_q.
    localparam int unsigned RD_LAT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StNumWait,
        StStream,
        StDrain,
        StDone
    } pos_state_e;

    // Largest particle count a cell of the given depth can legally hold
    // (address 0 is taken by the count word itself).
    function automatic int unsigned max_count(input int unsigned depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/pos_rd_lat_pipe.sv
// Valid + particle-id delay line that tracks reads in flight through the
// cell RAM so each returning word can be tagged with its address.
module pos_rd_lat_pipe #(
    parameter int unsigned PID_WIDTH = 8,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic [PID_WIDTH-1:0] i_pid,
    output logic                 o_valid,
    output logic [PID_WIDTH-1:0] o_pid,
    output logic                 o_inflight
);

    logic [DEPTH-1:0]     r_valid;
    logic [PID_WIDTH-1:0] r_pid [DEPTH];

    // Shift valid/pid one stage per cycle; clear drops anything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pid[i] <= '0;
            end
        end else if (i_clr) begin
            r_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pid[i] <= '0;
            end
        end else begin
            r_valid  <= {r_valid[DEPTH-2:0], i_valid};
            // Keep pid at zero on empty slots so rd_pid reads 0 when idle.
            r_pid[0] <= i_valid ? i_pid : '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pid[i] <= r_pid[i-1];
            end
        end
    end

    // Output stage plus a flag for reads not yet at the output stage.
    always_comb begin
        o_valid    = r_valid[DEPTH-1];
        o_pid      = r_pid[DEPTH-1];
        o_inflight = |r_valid[DEPTH-2:0];
    end

endmodule

// File: rtl/pos_cell_ctrl.sv
// Sequencing/arbitration controller for one single-port particle-position
// cell RAM. Streams every particle of the cell on request and lets the
// motion-update writer use the port whenever no stream is active.
module pos_cell_ctrl
    import pos_cell_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned PARTICLE_NUM = 220
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    // stream request / consumer side
    input  logic                  i_rd_start,
    input  logic                  i_rd_ready,
    output logic                  o_rd_busy,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH-1:0] o_rd_pid,
    output logic                  o_rd_done,
    output logic [ADDR_WIDTH-1:0] o_particle_num,
    output logic                  o_count_err,
    // motion-update writer
    input  logic                  i_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_grant,
    // RAM port
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_rden,
    output logic                  o_ram_wren,
    input  logic [DATA_WIDTH-1:0] i_ram_q
);

    localparam logic [ADDR_WIDTH-1:0] MAX_NUM   = ADDR_WIDTH'(max_count(PARTICLE_NUM));
    localparam logic [1:0]            WAIT_LAST = 2'(RD_LAT);
    localparam logic [ADDR_WIDTH-1:0] FIRST_PID = ADDR_WIDTH'(1);

    pos_state_e            r_state;
    logic [1:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;       // next particle address to issue
    logic [ADDR_WIDTH-1:0] r_num;
    logic                  r_count_err;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  r_ram_rden;
    logic                  r_ram_wren;
    logic                  r_issue_rd;   // current ram_rden is a particle read
    logic                  r_rd_done;

    logic [ADDR_WIDTH-1:0] w_count_raw;
    logic [ADDR_WIDTH-1:0] w_count;
    logic                  w_count_ovf;
    logic                  w_count_ready;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic                  w_issue_last;
    logic                  w_pipe_valid;
    logic [ADDR_WIDTH-1:0] w_pipe_pid;
    logic                  w_pipe_inflight;
    logic                  w_pipe_clr;

    // Count word decode and clamping to the legal cell depth.
    always_comb begin
        w_count_raw   = i_ram_q[ADDR_WIDTH-1:0];
        w_count_ovf   = (w_count_raw > MAX_NUM);
        w_count       = w_count_ovf ? MAX_NUM : w_count_raw;
        w_count_ready = (r_state == StNumWait) && (r_wait_cnt == WAIT_LAST);
    end

    // Decide whether a particle read goes out on the next edge. The first
    // address is issued straight out of NUM_WAIT so no cycle is lost.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = r_addr;
        w_issue_last = 1'b0;
        if (r_state == StStream) begin
            w_issue      = i_rd_ready;
            w_issue_addr = r_addr;
            w_issue_last = (r_addr == r_num);
        end else if (w_count_ready) begin
            w_issue      = i_rd_ready && (w_count != '0);
            w_issue_addr = FIRST_PID;
            w_issue_last = (w_count == FIRST_PID);
        end
    end

    // Main FSM with registered RAM-port and status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_wait_cnt    <= '0;
            r_addr        <= '0;
            r_num         <= '0;
            r_count_err   <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_rden    <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_issue_rd    <= 1'b0;
            r_rd_done     <= 1'b0;
        end else begin
            r_ram_rden <= 1'b0;
            r_ram_wren <= 1'b0;
            r_issue_rd <= 1'b0;
            r_rd_done  <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (i_rd_start) begin
                        r_state       <= StNumWait;
                        r_wait_cnt    <= '0;
                        r_ram_address <= '0;
                        r_ram_rden    <= 1'b1;
                    end else if (i_wr_req) begin
                        r_ram_address <= i_wr_addr;
                        r_ram_data    <= i_wr_data;
                        r_ram_wren    <= 1'b1;
                    end
                end
                StNumWait: begin
                    if (w_count_ready) begin
                        r_num       <= w_count;
                        r_count_err <= r_count_err | w_count_ovf;
                        r_addr      <= FIRST_PID;
                        // Empty cell still passes through DRAIN so rd_done
                        // keeps the same one-cycle settle as a real stream.
                        if (w_count == '0 || (w_issue && w_issue_last)) begin
                            r_state <= StDrain;
                        end else begin
                            r_state <= StStream;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                StStream: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    // Output-stage word is delivered this cycle; only wait on
                    // reads that have not reached it yet.
                    if (!r_issue_rd && !w_pipe_inflight) begin
                        r_state   <= StDone;
                        r_rd_done <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase

            // Particle read issue; the counter saturates at N.
            if (w_issue) begin
                r_ram_address <= w_issue_addr;
                r_ram_rden    <= 1'b1;
                r_issue_rd    <= 1'b1;
                if (!w_issue_last) begin
                    r_addr <= w_issue_addr + 1'b1;
                end
            end
        end
    end

    assign w_pipe_clr = (r_state == StIdle);

    pos_rd_lat_pipe #(
        .PID_WIDTH (ADDR_WIDTH),
        .DEPTH     (RD_LAT)
    ) u_rd_lat_pipe (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_pipe_clr),
        .i_valid    (r_issue_rd),
        .i_pid      (r_ram_address),
        .o_valid    (w_pipe_valid),
        .o_pid      (w_pipe_pid),
        .o_inflight (w_pipe_inflight)
    );

    // Output mapping; rd_data is masked so it reads 0 whenever not valid.
    always_comb begin
        o_rd_busy      = (r_state != StIdle);
        o_rd_valid     = w_pipe_valid;
        o_rd_pid       = w_pipe_pid;
        o_rd_data      = w_pipe_valid ? i_ram_q : '0;
        o_rd_done      = r_rd_done;
        o_particle_num = r_num;
        o_count_err    = r_count_err;
        // Reads win over writes; no grant while held in reset.
        o_wr_grant     = i_rst_n && (r_state == StIdle) && !i_rd_start;
        o_ram_address  = r_ram_address;
        o_ram_data     = r_ram_data;
        o_ram_rden     = r_ram_rden;
        o_ram_wren     = r_ram_wren;
    end

endmodule

// File: tb/tb_pos_cell_ctrl.sv
// Bench for pos_cell_ctrl: behavioural 2-cycle cell RAM, directed streams,
// and a scoreboard monitor that checks every rd_valid/rd_done against
// expectations queued by the stimulus.
module tb_pos_cell_ctrl;

    localparam int unsigned DW = 96;
    localparam int unsigned AW = 8;
    localparam int unsigned PN = 220;

    localparam logic [DW-1:0] DATA_A = 96'h0123_4567_89AB_CDEF_0000_0001;
    localparam logic [DW-1:0] DATA_B = 96'hFEDC_BA98_7654_3210_0000_0002;
    localparam logic [DW-1:0] DATA_C = 96'hA5A5_A5A5_5A5A_5A5A_0000_0003;
    localparam logic [DW-1:0] DATA_Z = 96'hDEAD_BEEF_CAFE_F00D_0000_0011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_start, rd_ready;
    logic          rd_busy, rd_valid, rd_done, count_err;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_pid, particle_num;
    logic          wr_req, wr_grant;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_rden, ram_wren;
    logic [DW-1:0] ram_q;

    // backdoor RAM loading, applied only while the DUT is idle
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ram_s1;

    int cyc = 0;
    int t0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] pid;
        logic [DW-1:0] data;
        int            rel;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      done_q[$];
    rd_exp_t mon_e;
    int      mon_d;

    pos_cell_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PARTICLE_NUM (PN)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rd_start     (rd_start),
        .i_rd_ready     (rd_ready),
        .o_rd_busy      (rd_busy),
        .o_rd_valid     (rd_valid),
        .o_rd_data      (rd_data),
        .o_rd_pid       (rd_pid),
        .o_rd_done      (rd_done),
        .o_particle_num (particle_num),
        .o_count_err    (count_err),
        .i_wr_req       (wr_req),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .o_wr_grant     (wr_grant),
        .o_ram_address  (ram_address),
        .o_ram_data     (ram_data),
        .o_ram_rden     (ram_rden),
        .o_ram_wren     (ram_wren),
        .i_ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-port RAM, address registered then one output register
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        else if (bd_we) mem[bd_addr] <= bd_data;
        if (ram_rden) ram_s1 <= mem[ram_address];
        ram_q <= ram_s1;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_stream: got pid %0d data %h at cycle %0d, required no output",
                             rd_pid, rd_data, cyc - t0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rd_pid !== mon_e.pid || rd_data !== mon_e.data || (cyc - t0) != mon_e.rel) begin
                        n_err++;
                        $display("FAIL rd_stream: got pid %0d data %h cycle %0d, required pid %0d data %h cycle %0d",
                                 rd_pid, rd_data, cyc - t0, mon_e.pid, mon_e.data, mon_e.rel);
                    end
                end
            end
            if (rd_done) begin
                n_vec++;
                if (done_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_done: got pulse at cycle %0d, required none", cyc - t0);
                end else begin
                    mon_d = done_q.pop_front();
                    if ((cyc - t0) != mon_d) begin
                        n_err++;
                        $display("FAIL rd_done: got cycle %0d, required cycle %0d", cyc - t0, mon_d);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] pat(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'h0BAD_0000 | 32'(i), 32'(i * 3)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int r);
        while ((cyc - t0) < r) step();
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        bd_we   = 1'b1;
        bd_addr = AW'(a);
        bd_data = d;
        step();
        bd_we   = 1'b0;
    endtask

    task automatic push_exp(input int pid, input logic [DW-1:0] d, input int rel);
        rd_exp_t e;
        e.pid  = AW'(pid);
        e.data = d;
        e.rel  = rel;
        exp_q.push_back(e);
    endtask

    // rd_start high for one cycle; that cycle is relative cycle 0
    task automatic start_read();
        rd_start = 1'b1;
        t0       = cyc;
        step();
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((rd_busy || exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d words and %0d done pulses outstanding, required 0",
                     name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_start = 1'b0;
        rd_ready = 1'b1;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;
        t0       = 0;

        // reset state
        repeat (3) step();
        chk("reset_busy", rd_busy, 0);
        chk("reset_rden", ram_rden, 0);
        chk("reset_wren", ram_wren, 0);
        chk("reset_grant", wr_grant, 0);
        rst_n = 1'b1;
        step();
        chk("idle_grant", wr_grant, 1);
        chk("idle_count_err", count_err, 0);

        // basic stream, N=3
        load(0, 96'd3);
        load(1, DATA_A);
        load(2, DATA_B);
        load(3, DATA_C);
        push_exp(1, DATA_A, 6);
        push_exp(2, DATA_B, 7);
        push_exp(3, DATA_C, 8);
        done_q.push_back(9);
        start_read();
        chk("basic_c1_addr", ram_address, 0);
        chk("basic_c1_rden", ram_rden, 1);
        chk("basic_c1_busy", rd_busy, 1);
        goto_rel(4);
        chk("basic_c4_num", particle_num, 3);
        chk("basic_c4_addr", ram_address, 1);
        chk("basic_c4_rden", ram_rden, 1);
        wait_done("basic", 40);
        chk("basic_busy_end_cycle", cyc - t0, 10);
        chk("basic_count_err", count_err, 0);

        // empty cell
        load(0, 96'd0);
        done_q.push_back(5);
        start_read();
        goto_rel(5);
        chk("empty_c5_busy", rd_busy, 1);
        goto_rel(6);
        chk("empty_c6_busy", rd_busy, 0);
        chk("empty_num", particle_num, 0);
        chk("empty_done_seen", done_q.size(), 0);

        // overflowing count clamps to PN-1
        load(0, 96'd250);
        for (int i = 1; i < int'(PN); i++) load(i, pat(i));
        for (int i = 1; i < int'(PN); i++) push_exp(i, pat(i), 5 + i);
        done_q.push_back(225);
        start_read();
        wait_done("overflow", 400);
        chk("overflow_num", particle_num, 219);
        chk("overflow_count_err", count_err, 1);

        // backpressure: rd_ready low in cycles 5..7
        load(0, 96'd4);
        push_exp(1, pat(1), 6);
        push_exp(2, pat(2), 7);
        push_exp(3, pat(3), 11);
        push_exp(4, pat(4), 12);
        done_q.push_back(13);
        start_read();
        goto_rel(5);
        rd_ready = 1'b0;
        goto_rel(6);
        chk("stall_rden", ram_rden, 0);
        chk("stall_addr_held", ram_address, 2);
        goto_rel(8);
        rd_ready = 1'b1;
        wait_done("stall", 40);
        chk("stall_count_err_sticky", count_err, 1);

        // arbitration: write requested together with rd_start, N=2
        load(0, 96'd2);
        push_exp(1, pat(1), 6);
        push_exp(2, pat(2), 7);
        done_q.push_back(8);
        rd_start = 1'b1;
        wr_req   = 1'b1;
        wr_addr  = 8'd0;
        wr_data  = 96'd1;
        t0       = cyc;
        #1;
        chk("arb_c0_grant", wr_grant, 0);
        step();
        rd_start = 1'b0;
        goto_rel(3);
        chk("arb_c3_wren", ram_wren, 0);
        goto_rel(8);
        chk("arb_c8_grant", wr_grant, 0);
        goto_rel(9);
        chk("arb_c9_grant", wr_grant, 1);
        step();
        chk("arb_w1_wren", ram_wren, 1);
        chk("arb_w1_addr", ram_address, 0);
        chk("arb_w1_data", ram_data, 96'd1);
        wr_addr = 8'd1;
        wr_data = DATA_Z;
        step();
        chk("arb_w2_wren", ram_wren, 1);
        chk("arb_w2_addr", ram_address, 1);
        chk("arb_w2_data", ram_data, DATA_Z);
        wr_req = 1'b0;
        step();
        chk("arb_w3_wren", ram_wren, 0);
        chk("arb_stream_drained", exp_q.size() + done_q.size(), 0);

        // read-after-write: count 1 and particle 1 written through the port
        push_exp(1, DATA_Z, 6);
        done_q.push_back(7);
        start_read();
        goto_rel(4);
        chk("raw_num", particle_num, 1);
        wait_done("raw", 40);

        // reset in the middle of a 5-particle stream
        load(0, 96'd5);
        push_exp(1, DATA_Z, 6);
        for (int i = 2; i <= 5; i++) push_exp(i, pat(i), 5 + i);
        done_q.push_back(11);
        start_read();
        goto_rel(7);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        chk("mid_rst_busy", rd_busy, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_pid", rd_pid, 0);
        chk("mid_rst_done", rd_done, 0);
        chk("mid_rst_num", particle_num, 0);
        chk("mid_rst_addr", ram_address, 0);
        chk("mid_rst_rden", ram_rden, 0);
        chk("mid_rst_grant", wr_grant, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_grant", wr_grant, 1);
        chk("post_rst_count_err", count_err, 0);

        // clean stream after reset; extra rd_start mid-stream is ignored
        load(0, 96'd3);
        load(1, DATA_A);
        load(2, DATA_B);
        load(3, DATA_C);
        push_exp(1, DATA_A, 6);
        push_exp(2, DATA_B, 7);
        push_exp(3, DATA_C, 8);
        done_q.push_back(9);
        start_read();
        goto_rel(5);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        wait_done("post_rst", 40);
        chk("post_rst_num", particle_num, 3);
        repeat (3) step();
        chk("post_rst_idle_busy", rd_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
